// File: rtl/cpu_pkg.sv
// Shared constants and state type for the CPU front end (PC width, offset width, reset vector).
package cpu_pkg;
    localparam int          PC_W     = 32;
    localparam int          OFF_W    = 8;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          STAT_W   = 16;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        STALL    = 2'd2
    } pc_state_t;
endpackage

// File: rtl/pc_update_unit_branch_target_calc.sv
// Combinational next-PC datapath: PC+4, sign-extended word offset, branch target and taken decision.
module branch_target_calc #(
    parameter int PC_W  = 32,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] offset,
    input  logic             jump,
    input  logic             beq,
    input  logic             bne,
    input  logic             zero,
    output logic [PC_W-1:0]  pc_plus4,
    output logic [PC_W-1:0]  target,
    output logic             taken
);
    logic [PC_W-1:0] ext;

    assign pc_plus4 = pc + PC_W'(4);
    assign ext      = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
    // Offset counts instructions, so scale to bytes; wrap-around is intentional.
    assign target   = pc_plus4 + (ext << 2);
    assign taken    = jump | (beq & zero) | (bne & ~zero);
endmodule

// File: rtl/pc_update_unit.sv
// PC register with reset-hold / run / stall sequencing.
// Optional branch/stall counters are compiled in with PC_BRANCH_STATS_EN.
module pc_update_unit #(
    parameter int              PC_W     = cpu_pkg::PC_W,
    parameter int              OFF_W    = cpu_pkg::OFF_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(cpu_pkg::RESET_PC)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [OFF_W-1:0] OFFSET,
    input  logic             JUMP,
    input  logic             BEQ,
    input  logic             BNE,
    input  logic             ZERO,
    input  logic             BUSYWAIT,
    output logic [PC_W-1:0]  PC,
    output logic [PC_W-1:0]  PC_PLUS4,
    output logic             TAKEN
`ifdef PC_BRANCH_STATS_EN
   ,output logic [15:0]      BR_TAKEN_CNT,
    output logic [15:0]      STALL_CNT
`endif
);
    import cpu_pkg::*;

    pc_state_t       state, next_state;
    logic [PC_W-1:0] target, next_pc;
    logic            pc_load;

    branch_target_calc #(.PC_W(PC_W), .OFF_W(OFF_W)) u_btc (
        .pc       (PC),
        .offset   (OFFSET),
        .jump     (JUMP),
        .beq      (BEQ),
        .bne      (BNE),
        .zero     (ZERO),
        .pc_plus4 (PC_PLUS4),
        .target   (target),
        .taken    (TAKEN)
    );

    assign next_pc = TAKEN ? target : PC_PLUS4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= RST_HOLD;
        else        state <= next_state;
    end

    // BUSYWAIT is ignored in RST_HOLD so RESET_PC always gets one full fetch cycle.
    always_comb begin
        next_state = state;
        case (state)
            RST_HOLD: next_state = RUN;
            RUN:      next_state = BUSYWAIT ? STALL : RUN;
            STALL:    next_state = BUSYWAIT ? STALL : RUN;
            default:  next_state = RST_HOLD;
        endcase
    end

    always_comb begin
        pc_load = 1'b0;
        case (state)
            RUN, STALL: pc_load = ~BUSYWAIT;
            default:    pc_load = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)       PC <= RESET_PC;
        else if (pc_load) PC <= next_pc;
    end

`ifdef PC_BRANCH_STATS_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            BR_TAKEN_CNT <= '0;
            STALL_CNT    <= '0;
        end else begin
            if (pc_load && TAKEN && BR_TAKEN_CNT != 16'hFFFF)
                BR_TAKEN_CNT <= BR_TAKEN_CNT + 16'd1;
            // Counts edges entering or remaining in STALL, not the release edge.
            if (next_state == STALL && STALL_CNT != 16'hFFFF)
                STALL_CNT <= STALL_CNT + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pc_update_unit.sv
// Self-checking bench for pc_update_unit: directed vector table, stall/reset sequences, random vs model.
module tb_pc_update_unit;
    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [7:0]  OFFSET = '0;
    logic        JUMP = 1'b0, BEQ = 1'b0, BNE = 1'b0, ZERO = 1'b0, BUSYWAIT = 1'b0;
    logic [31:0] PC, PC_PLUS4;
    logic        TAKEN;
`ifdef PC_BRANCH_STATS_EN
    logic [15:0] BR_TAKEN_CNT, STALL_CNT;
`endif

    int n_chk = 0;
    int n_fail = 0;

    pc_update_unit dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .OFFSET   (OFFSET),
        .JUMP     (JUMP),
        .BEQ      (BEQ),
        .BNE      (BNE),
        .ZERO     (ZERO),
        .BUSYWAIT (BUSYWAIT),
        .PC       (PC),
        .PC_PLUS4 (PC_PLUS4),
        .TAKEN    (TAKEN)
`ifdef PC_BRANCH_STATS_EN
       ,.BR_TAKEN_CNT (BR_TAKEN_CNT),
        .STALL_CNT    (STALL_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] pc0;
        logic [7:0]  off;
        logic        j, beq, bne, z;
        logic        exp_taken;
        logic [31:0] exp_next;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        OFFSET = '0; JUMP = 0; BEQ = 0; BNE = 0; ZERO = 0; BUSYWAIT = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        RESET = 0;
        step();
        step();
        RESET = 1;
    endtask

    // Reset, take the hold edge, then fetch sequentially up to target.
    task automatic reach(input logic [31:0] target);
        do_reset();
        step();
        repeat (int'(target >> 2)) step();
    endtask

    function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [7:0] off);
        int s;
        s = $signed(off);
        return pc + 32'd4 + 32'(s * 4);
    endfunction

    initial begin
        vecs[0] = '{32'h10, 8'h03, 0, 1, 0, 1, 1, 32'h20};
        vecs[1] = '{32'h10, 8'h03, 0, 0, 1, 1, 0, 32'h14};
        vecs[2] = '{32'h40, 8'hFC, 1, 0, 0, 0, 1, 32'h34};
        vecs[3] = '{32'h00, 8'h80, 1, 0, 0, 0, 1, 32'hFFFF_FE04};
        vecs[4] = '{32'h10, 8'h7F, 0, 0, 1, 0, 1, 32'h210};
        vecs[5] = '{32'h20, 8'h05, 0, 1, 0, 0, 0, 32'h24};
        vecs[6] = '{32'h40, 8'h80, 1, 1, 1, 0, 1, 32'hFFFF_FE44};
        vecs[7] = '{32'h0C, 8'hFF, 0, 1, 1, 1, 1, 32'h0C};
        vecs[8] = '{32'h04, 8'h00, 0, 0, 0, 1, 0, 32'h08};

        // Reset and sequential fetch
        #1;
        check("reset_pc", PC, 32'h0);
        check("reset_pc_plus4", PC_PLUS4, 32'h4);
        do_reset();
        check("rst_hold_pc", PC, 32'h0);
`ifdef PC_BRANCH_STATS_EN
        check("reset_br_cnt", 32'(BR_TAKEN_CNT), 32'h0);
        check("reset_stall_cnt", 32'(STALL_CNT), 32'h0);
`endif
        step(); check("seq_edge1", PC, 32'h0);
        step(); check("seq_edge2", PC, 32'h4);
        step(); check("seq_edge3", PC, 32'h8);
        step(); check("seq_edge4", PC, 32'hC);

        // Directed next-PC vectors
        for (int i = 0; i < 9; i++) begin
            reach(vecs[i].pc0);
            check($sformatf("vec%0d_pc0", i), PC, vecs[i].pc0);
            OFFSET = vecs[i].off; JUMP = vecs[i].j; BEQ = vecs[i].beq;
            BNE = vecs[i].bne; ZERO = vecs[i].z;
            #1;
            check($sformatf("vec%0d_taken", i), 32'(TAKEN), 32'(vecs[i].exp_taken));
            check($sformatf("vec%0d_plus4", i), PC_PLUS4, vecs[i].pc0 + 32'd4);
            step();
            check($sformatf("vec%0d_next", i), PC, vecs[i].exp_next);
        end

        // Stall then branch
        reach(32'h08);
        BEQ = 1; ZERO = 1; OFFSET = 8'h01; BUSYWAIT = 1;
        for (int k = 1; k <= 3; k++) begin
            step();
            check($sformatf("stall_hold%0d", k), PC, 32'h08);
        end
        BUSYWAIT = 0;
        step();
        check("stall_redirect", PC, 32'h10);
`ifdef PC_BRANCH_STATS_EN
        check("stall_cnt", 32'(STALL_CNT), 32'd3);
        check("br_taken_cnt", 32'(BR_TAKEN_CNT), 32'd1);
`endif

        // Async reset mid-stall, BUSYWAIT kept high through the hold edge
        reach(32'h30);
        BUSYWAIT = 1;
        step(); step();
        check("mid_stall_pc", PC, 32'h30);
        #3 RESET = 0;
        #1 check("async_reset_pc", PC, 32'h0);
`ifdef PC_BRANCH_STATS_EN
        check("async_reset_stall_cnt", 32'(STALL_CNT), 32'h0);
`endif
        #1 RESET = 1;
        step();
        check("post_reset_hold", PC, 32'h0);
        BUSYWAIT = 0;
        step();
        check("post_reset_adv", PC, 32'h4);

        // Random instruction stream against a behavioural model
        begin
            logic [31:0] m_pc;
            logic        m_first, m_tk;
            int          m_br, m_st;
            do_reset();
            m_pc = 32'h0; m_first = 1; m_br = 0; m_st = 0;
            for (int c = 0; c < 400; c++) begin
                OFFSET   = 8'($urandom);
                JUMP     = ($urandom_range(0, 9) == 0);
                BEQ      = ($urandom_range(0, 3) == 0);
                BNE      = ($urandom_range(0, 3) == 0);
                ZERO     = 1'($urandom);
                BUSYWAIT = ($urandom_range(0, 3) == 0);
                #1;
                m_tk = JUMP || (BEQ && ZERO) || (BNE && !ZERO);
                check("rnd_taken", 32'(TAKEN), 32'(m_tk));
                check("rnd_plus4", PC_PLUS4, m_pc + 32'd4);
                if (m_first) m_first = 0;
                else if (BUSYWAIT) m_st++;
                else if (m_tk) begin m_pc = model_target(m_pc, OFFSET); m_br++; end
                else m_pc = m_pc + 32'd4;
                step();
                check("rnd_pc", PC, m_pc);
            end
`ifdef PC_BRANCH_STATS_EN
            check("rnd_br_cnt", 32'(BR_TAKEN_CNT), 32'(m_br));
            check("rnd_stall_cnt", 32'(STALL_CNT), 32'(m_st));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
